// File: rtl/mul16_seq_pkg.sv
// Shared definitions for the 16x16 digit-serial multiplier: geometry, state
// encoding, and the digit-select / alignment helpers used by the datapath.
package mul16_seq_pkg;

   localparam int WIDTH  = 16;
   localparam int DIGIT  = 4;
   localparam int STEPS  = 4;
   localparam int STEP_W = 2;
   localparam int ACC_W  = 2 * WIDTH;
   localparam int PP_W   = WIDTH + DIGIT;

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Multiplier nibble consumed at a given step, least significant first.
   function automatic logic [DIGIT-1:0] digit_of(input logic [WIDTH-1:0] b,
                                                 input logic [STEP_W-1:0] step);
      logic [DIGIT-1:0] d;
      d = 4'd0;
      case (step)
         2'd0:    d = b[3:0];
         2'd1:    d = b[7:4];
         2'd2:    d = b[11:8];
         2'd3:    d = b[15:12];
         default: d = 4'd0;
      endcase
      return d;
   endfunction

   function automatic logic [ACC_W-1:0] align_pp(input logic [PP_W-1:0] pp,
                                                 input logic [STEP_W-1:0] step);
      logic [ACC_W-1:0] wide;
      wide = {12'd0, pp};
      return wide << {step, 2'b00};
   endfunction

endpackage

// File: rtl/mul16_pp4.sv
// Combinational 16x4 partial-product generator; the top time-shares a single
// instance across all four digit steps.
module mul16_pp4
   import mul16_seq_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic [DIGIT-1:0] d,
   output logic [PP_W-1:0]  pp
);

   logic [PP_W-1:0] a_ext_s;
   logic [PP_W-1:0] d_ext_s;

   assign a_ext_s = {4'd0, a};
   assign d_ext_s = {16'd0, d};
   assign pp      = a_ext_s * d_ext_s;

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier: one 4-bit multiplier digit per cycle,
// low 16 result bits plus an unsigned overflow flag, one result per 5 cycles.
module mul16_seq
   import mul16_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic             overflow
);

   state_t            state_r;
   logic [STEP_W-1:0] step_r;
   logic [WIDTH-1:0]  a_r;
   logic [WIDTH-1:0]  b_r;
   logic [ACC_W-1:0]  acc_r;
   logic [WIDTH-1:0]  product_r;
   logic              overflow_r;
   logic              busy_r;
   logic              done_r;

   logic [DIGIT-1:0]  digit_s;
   logic [PP_W-1:0]   pp_s;
   logic [ACC_W-1:0]  acc_next_s;

   mul16_pp4 u_pp4 (
      .a  (a_r),
      .d  (digit_s),
      .pp (pp_s)
   );

   // Select the current digit and form the next accumulator value.
   always_comb begin
      digit_s    = digit_of(b_r, step_r);
      acc_next_s = acc_r + align_pp(pp_s, step_r);
   end

   // Control FSM with datapath registers; DONE accepts a new start for back-to-back use.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         step_r     <= 2'd0;
         a_r        <= 16'd0;
         b_r        <= 16'd0;
         acc_r      <= 32'd0;
         product_r  <= 16'd0;
         overflow_r <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  a_r     <= ina;
                  b_r     <= inb;
                  acc_r   <= 32'd0;
                  step_r  <= 2'd0;
                  state_r <= RUN;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            RUN: begin
               acc_r  <= acc_next_s;
               step_r <= step_r + 2'd1;
               if (step_r == LAST_STEP) begin
                  state_r    <= DONE;
                  product_r  <= acc_next_s[15:0];
                  overflow_r <= |acc_next_s[31:16];
                  busy_r     <= 1'b0;
                  done_r     <= 1'b1;
               end else begin
                  state_r <= RUN;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               step_r  <= 2'd0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign product  = product_r;
   assign overflow = overflow_r;

endmodule

// File: tb/tb_mul16_seq.sv
// Self-checking bench for mul16_seq: directed cases plus random operands,
// compared against plain 32-bit arithmetic.
module tb_mul16_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] ina;
   logic [15:0] inb;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        overflow;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul16_seq dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ina      (ina),
      .inb      (inb),
      .busy     (busy),
      .done     (done),
      .product  (product),
      .overflow (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] wa;
      logic [31:0] wb;
      wa = {16'd0, a};
      wb = {16'd0, b};
      return wa * wb;
   endfunction

   // mode 0: quiet inputs during RUN; 1: random noise; 2: start with 7*7
   task automatic mul_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input int mode);
      logic [31:0] p;
      logic [15:0] held;
      int n;
      int bc;
      bit stable;
      p = ref_mul(a, b);
      @(negedge clk);
      ina = a; inb = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0; bc = 0; held = product; stable = 1'b1;
      while (!done && n < 20) begin
         if (busy) bc++;
         if (product !== held) stable = 1'b0;
         if (mode == 1) begin
            ina = 16'($urandom); inb = 16'($urandom); start = 1'($urandom_range(0, 1));
         end else if (mode == 2) begin
            ina = 16'd7; inb = 16'd7; start = 1'b1;
         end
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      check({tag, " latency"}, n, 4);
      check({tag, " busy_cycles"}, bc, 4);
      check({tag, " product_held"}, stable, 1);
      check({tag, " product"}, product, p[15:0]);
      check({tag, " overflow"}, overflow, (p >= 32'h10000) ? 1 : 0);
      check({tag, " busy_in_done"}, busy, 0);
      @(negedge clk);
      check({tag, " done_pulse"}, {busy, done}, 0);
   endtask

   initial begin
      int n;
      int d1;
      int d2;
      rst = 1'b1; start = 1'b0; ina = 16'd0; inb = 16'd0;
      repeat (2) @(negedge clk);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset product", product, 0);
      check("reset overflow", overflow, 0);
      rst = 1'b0;

      mul_op("3x5", 16'd3, 16'd5, 0);
      mul_op("ffff_sq", 16'hFFFF, 16'hFFFF, 0);
      mul_op("ff_x_101", 16'h00FF, 16'h0101, 0);
      mul_op("100_sq", 16'h0100, 16'h0100, 0);
      mul_op("2x3_start_ignored", 16'd2, 16'd3, 2);
      mul_op("zero_a", 16'd0, 16'hABCD, 1);
      mul_op("zero_b", 16'hABCD, 16'd0, 0);
      for (int i = 0; i < 8; i++) begin
         mul_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1);
      end

      // back-to-back with start held high
      @(negedge clk);
      ina = 16'd2; inb = 16'd2; start = 1'b1;
      @(negedge clk);
      ina = 16'd4; inb = 16'd4;
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      d1 = n;
      check("b2b first latency", d1, 4);
      check("b2b first product", product, 16'h0004);
      check("b2b first overflow", overflow, 0);
      @(negedge clk); n++;
      while (!done && n < 30) begin @(negedge clk); n++; end
      d2 = n;
      start = 1'b0;
      check("b2b spacing", d2 - d1, 5);
      check("b2b second product", product, 16'h0010);
      @(negedge clk);
      check("b2b end", {busy, done}, 0);

      // abort a multiply with reset in its second RUN cycle
      mul_op("pre_abort", 16'd3, 16'd7, 0);
      @(negedge clk);
      ina = 16'h1234; inb = 16'h0010; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("abort first run", busy, 1);
      @(negedge clk);
      check("abort second run", busy, 1);
      rst = 1'b1; start = 1'b1; ina = 16'd9; inb = 16'd9;
      @(negedge clk);
      check("abort product", product, 0);
      check("abort overflow", overflow, 0);
      check("abort busy_done", {busy, done}, 0);
      @(negedge clk);
      check("rst wins over start", {busy, done}, 0);
      rst = 1'b0;
      @(negedge clk);
      start = 1'b0;
      check("post_rst accept", busy, 1);
      n = 0;
      while (!done && n < 20) begin @(negedge clk); n++; end
      check("9x9 latency", n, 4);
      check("9x9 product", product, 16'h0051);
      check("9x9 overflow", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request a multiply; sampled on a rising edge of clk.
REQ-004 The block SHALL have port ina, input, 16 bits: unsigned multiplicand, captured when start is accepted.
REQ-005 The block SHALL have port inb, input, 16 bits: unsigned multiplier, captured when start is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse, result valid.
REQ-008 The block SHALL have port product, output, 16 bits: low 16 bits of the last completed product.
REQ-009 The block SHALL have port overflow, output, 1 bit: high when the last completed product exceeds 16 bits.

Function
REQ-010 The block SHALL have three states: IDLE, RUN and DONE.
REQ-011 In IDLE or DONE, start=1 at an edge SHALL latch ina/inb into internal registers, clear the 32-bit accumulator, set step=0 and enter RUN.
REQ-012 In RUN, start SHALL be ignored, and input changes SHALL NOT affect the operation in progress.
REQ-013 Each RUN edge SHALL add (a_reg * b_reg[4*step+3:4*step]) << (4*step) to the accumulator, using 32-bit unsigned arithmetic with no truncation, then increment step.
REQ-014 At the RUN edge with step=3, the block SHALL enter DONE, load product with acc_next[15:0], and load overflow with |acc_next[31:16].
REQ-015 Timing: start is sampled at edge E0, accumulation occurs at E1..E4, and done=1 holds for the single cycle after E4.
REQ-016 Latency from start sample to done SHALL be exactly 4 cycles; throughput SHALL be one result per 5 cycles.
REQ-017 DONE SHALL last exactly one cycle, then go to IDLE, or to RUN if start=1 (back-to-back operation).
REQ-018 product and overflow SHALL hold their values until the next DONE entry; they SHALL NOT change during RUN.
REQ-019 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE; busy and done SHALL never be high together.
REQ-020 Zero operands SHALL take the same 4-step path; there SHALL be no early termination.
REQ-021 Overflow SHALL be unsigned: set if and only if the true 32-bit product is 0x10000 or greater.

Reset
REQ-022 rst=1 at an edge SHALL force state=IDLE, step=0, acc=0, product=0, overflow=0, busy=0 and done=0, overriding start.
REQ-023 rst during RUN SHALL abort the operation with no done pulse; the previous product SHALL be cleared to 0.
REQ-024 If rst and start are high at the same edge, reset SHALL win; start SHALL be accepted no earlier than the first edge with rst=0.

Structure
REQ-025 Package mul16_seq_pkg SHALL hold the state encoding (IDLE/RUN/DONE), WIDTH=16, DIGIT=4, STEPS=4 and STEP_W=2.
REQ-026 The 16x4 partial product SHALL be a combinational sub-module mul16_pp4 (inputs a[15:0], d[3:0]; output pp[19:0]), instantiated once and time-shared across all four steps.
REQ-027 Shift-align and accumulate SHALL be in the top level; no second multiplier instance is permitted.

Verification
REQ-028 The bench SHALL run ina=3, inb=5, start pulse -> done 4 cycles later, product=0x000F, overflow=0.
REQ-029 The bench SHALL run ina=0xFFFF, inb=0xFFFF -> product=0x0001, overflow=1.
REQ-030 The bench SHALL run ina=0x00FF, inb=0x0101 -> product=0xFFFF, overflow=0; then ina=0x0100, inb=0x0100 -> product=0x0000, overflow=1.
REQ-031 The bench SHALL run 2*3 and, during RUN, assert start with ina=7, inb=7 -> ignored; result=0x0006; busy high for exactly 4 cycles.
REQ-032 The bench SHALL hold start high continuously with operands 2*2 then 4*4 -> done pulses 5 cycles apart, products 0x0004 then 0x0010.
REQ-033 The bench SHALL assert rst at the second RUN cycle of 0x1234*0x0010 -> no done pulse, outputs zero, next 9*9 gives product=0x0051.
